// File: rtl/mmio_bridge.sv
// mmio_bridge: steers execute-stage load/store traffic to data memory or to
// one of NUM_CH memory-mapped IO channels. IO accesses go through a small
// IDLE -> ACCESS -> DONE handshake that stalls the CPU, captures read data,
// and flags out-of-window requests, memory/IO conflicts and timeouts.
module mmio_bridge #(
    parameter int          NUM_CH    = 4,
    parameter int          IO_DW     = 16,
    parameter logic [31:0] IO_BASE   = 32'hFFFFFC60,
    parameter int          SPAN_LOG2 = 4,
    parameter int          MIN_WAIT  = 1,
    parameter int          TIMEOUT   = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             addr_result,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    io_read,
    input  logic                    io_write,
    input  logic [31:0]             wdata,
    input  logic [31:0]             mem_rdata,
    input  logic [NUM_CH*IO_DW-1:0] io_rdata,
    input  logic [NUM_CH-1:0]       io_ready,
    output logic [31:0]             address,
    output logic [31:0]             write_data,
    output logic [31:0]             rdata,
    output logic [NUM_CH-1:0]       io_cs,
    output logic                    io_rd_en,
    output logic                    io_wr_en,
    output logic [IO_DW-1:0]        io_wdata,
    output logic                    stall,
    output logic                    bus_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CH_W-1:0]     r_ch;
    logic [7:0]          r_cnt;
    logic [IO_DW-1:0]    r_cap;
    logic [NUM_CH-1:0]   r_cs;
    logic                r_rd_en;
    logic                r_wr_en;
    logic [IO_DW-1:0]    r_wdata;
    logic                r_bus_err;

    logic                w_mem_cyc;
    logic                w_io_any;
    logic                w_io_req;
    logic [31:0]         w_ch_full;
    logic                w_in_win;
    logic [CH_W-1:0]     w_ch;
    logic                w_start;
    logic                w_oow;
    logic [8:0]          w_cnt_nxt;
    logic                w_ready_sel;
    logic                w_complete;
    logic                w_timeout;
    logic [IO_DW-1:0]    w_rd_slice;

    // Memory requests always win; an IO request only counts when no memory access is present.
    assign w_mem_cyc   = mem_read | mem_write;
    assign w_io_any    = io_read | io_write;
    assign w_io_req    = w_io_any & ~w_mem_cyc;

    // Addresses below IO_BASE wrap to a huge offset, but the explicit >= test rejects them anyway.
    assign w_ch_full   = (addr_result - IO_BASE) >> SPAN_LOG2;
    assign w_in_win    = (addr_result >= IO_BASE) && (w_ch_full < 32'(NUM_CH));
    assign w_ch        = w_ch_full[CH_W-1:0];

    assign w_start     = (r_state == S_IDLE) & w_io_req & w_in_win;
    assign w_oow       = (r_state == S_IDLE) & w_io_req & ~w_in_win;

    // The counter value including the current ACCESS cycle, so MIN_WAIT=1 completes after one cycle.
    assign w_cnt_nxt   = {1'b0, r_cnt} + 9'd1;
    assign w_ready_sel = io_ready[r_ch];
    assign w_complete  = (r_state == S_ACCESS) & (w_cnt_nxt >= 9'(MIN_WAIT)) & w_ready_sel;
    assign w_timeout   = (r_state == S_ACCESS) & ~w_complete & (w_cnt_nxt >= 9'(TIMEOUT));
    assign w_rd_slice  = io_rdata[int'(r_ch)*IO_DW +: IO_DW];

    assign address     = addr_result;
    assign write_data  = mem_write ? wdata : 32'd0;
    assign io_cs       = r_cs;
    assign io_rd_en    = r_rd_en;
    assign io_wr_en    = r_wr_en;
    assign io_wdata    = r_wdata;
    assign bus_err     = r_bus_err;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE always lasts one cycle and ignores the still-held request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_complete || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: stall and the writeback data mux.
    always_comb begin
        stall = 1'b0;
        rdata = 32'(r_cap);
        case (r_state)
            S_IDLE:   stall = w_io_req & w_in_win;
            S_ACCESS: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
        // Release the pipeline immediately when reset drops an in-flight access.
        if (reset) begin
            stall = 1'b0;
        end
        if (w_mem_cyc) begin
            rdata = mem_rdata;
        end else if (w_oow) begin
            rdata = 32'd0;
        end
    end

    // Channel select, strobes, store data, wait counter and read-data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ch    <= '0;
            r_cnt   <= 8'd0;
            r_cap   <= '0;
            r_cs    <= '0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_ch    <= w_ch;
            r_cnt   <= 8'd0;
            r_cs    <= NUM_CH'(1) << w_ch;
            r_rd_en <= io_read;
            r_wr_en <= io_write;
            r_wdata <= wdata[IO_DW-1:0];
        end else if (r_state == S_ACCESS) begin
            r_cnt <= w_cnt_nxt[7:0];
            if (w_complete) begin
                if (r_rd_en) begin
                    r_cap <= w_rd_slice;
                end
                r_cs    <= '0;
                r_rd_en <= 1'b0;
                r_wr_en <= 1'b0;
            end else if (w_timeout) begin
                r_cap   <= '0;
                r_cs    <= '0;
                r_rd_en <= 1'b0;
                r_wr_en <= 1'b0;
            end
        end
    end

    // Sticky bus error: memory/IO conflict, out-of-window IO request, or access timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if ((w_mem_cyc & w_io_any) | w_oow | w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge. Stimulus pushes the expected writeback
// data into a queue; a monitor pops and compares whenever the CPU would
// sample rdata (request present, no stall). Control outputs are checked
// inline by the stimulus.
module tb_mmio_bridge;

    logic        clock;
    logic        reset;
    logic [31:0] addr_result;
    logic        mem_read, mem_write, io_read, io_write;
    logic [31:0] wdata, mem_rdata;
    logic [63:0] io_rdata;
    logic [3:0]  io_ready;
    logic [31:0] address, write_data, rdata;
    logic [3:0]  io_cs;
    logic        io_rd_en, io_wr_en;
    logic [15:0] io_wdata;
    logic        stall, bus_err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mmio_bridge dut (
        .clock(clock), .reset(reset), .addr_result(addr_result),
        .mem_read(mem_read), .mem_write(mem_write),
        .io_read(io_read), .io_write(io_write),
        .wdata(wdata), .mem_rdata(mem_rdata),
        .io_rdata(io_rdata), .io_ready(io_ready),
        .address(address), .write_data(write_data), .rdata(rdata),
        .io_cs(io_cs), .io_rd_en(io_rd_en), .io_wr_en(io_wr_en),
        .io_wdata(io_wdata), .stall(stall), .bus_err(bus_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        io_read   = 1'b0;
        io_write  = 1'b0;
    endtask

    // Monitor: the CPU consumes rdata on any request cycle without stall.
    always @(negedge clock) begin
        if (!reset && (mem_read || mem_write || io_read || io_write) && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%h expected=none", rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    failures++;
                    $display("FAIL sb_rdata actual=%h expected=%h t=%0t", rdata, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        addr_result = 32'h0;
        wdata       = 32'h0;
        mem_rdata   = 32'h0;
        io_rdata    = {16'h3333, 16'h2222, 16'hA5A5, 16'h1111};
        io_ready    = 4'b1111;
        clear_req();
        tick(); tick();
        #2;
        chk("rst_cs",      32'(io_cs),    32'h0);
        chk("rst_rd_en",   32'(io_rd_en), 32'h0);
        chk("rst_wr_en",   32'(io_wr_en), 32'h0);
        chk("rst_wdata",   32'(io_wdata), 32'h0);
        chk("rst_stall",   32'(stall),    32'h0);
        chk("rst_bus_err", 32'(bus_err),  32'h0);
        chk("rst_rdata",   rdata,         32'h0);
        tick();
        reset = 1'b0;

        // IO read, channel 1, ready already high: stall, ACCESS, DONE.
        tick();
        addr_result = 32'hFFFFFC70;
        io_read     = 1'b1;
        exp_q.push_back(32'h0000A5A5);
        #2;
        chk("rd_c0_stall", 32'(stall), 32'h1);
        chk("rd_c0_cs",    32'(io_cs), 32'h0);
        chk("rd_address",  address,    32'hFFFFFC70);
        tick(); #2;
        chk("rd_c1_cs",    32'(io_cs),    32'h2);
        chk("rd_c1_rd_en", 32'(io_rd_en), 32'h1);
        chk("rd_c1_wr_en", 32'(io_wr_en), 32'h0);
        chk("rd_c1_stall", 32'(stall),    32'h1);
        tick(); #2;
        chk("rd_c2_stall", 32'(stall),    32'h0);
        chk("rd_c2_cs",    32'(io_cs),    32'h0);
        chk("rd_c2_rd_en", 32'(io_rd_en), 32'h0);
        chk("rd_c2_rdata", rdata,         32'h0000A5A5);
        tick();
        clear_req();
        #2;
        chk("idle_rdata_hold", rdata, 32'h0000A5A5);

        // IO write, channel 0, ready raised in the 4th ACCESS cycle.
        tick();
        io_ready    = 4'b1110;
        addr_result = 32'hFFFFFC60;
        wdata       = 32'h1234ABCD;
        io_write    = 1'b1;
        exp_q.push_back(32'h0000A5A5);
        #2;
        chk("wr_c0_stall", 32'(stall),  32'h1);
        chk("wr_c0_wdata", write_data,  32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 4) io_ready = 4'b1111;
            #2;
            chk("wr_acc_stall", 32'(stall),    32'h1);
            chk("wr_acc_wr_en", 32'(io_wr_en), 32'h1);
            chk("wr_acc_cs",    32'(io_cs),    32'h1);
            chk("wr_acc_iowd",  32'(io_wdata), 32'h0000ABCD);
            chk("wr_acc_wdata", write_data,    32'h0);
        end
        tick(); #2;
        chk("wr_done_stall", 32'(stall),    32'h0);
        chk("wr_done_wr_en", 32'(io_wr_en), 32'h0);
        chk("wr_done_cs",    32'(io_cs),    32'h0);
        chk("wr_bus_err",    32'(bus_err),  32'h0);
        tick();
        clear_req();

        // Plain memory read and write.
        addr_result = 32'h00000100;
        mem_rdata   = 32'h11223344;
        mem_read    = 1'b1;
        exp_q.push_back(32'h11223344);
        #2;
        chk("mrd_stall", 32'(stall), 32'h0);
        chk("mrd_rdata", rdata,      32'h11223344);
        tick();
        clear_req();
        mem_write = 1'b1;
        wdata     = 32'hDEADBEEF;
        exp_q.push_back(32'h11223344);
        #2;
        chk("mwr_write_data", write_data,   32'hDEADBEEF);
        chk("mwr_stall",      32'(stall),   32'h0);
        tick();
        clear_req();
        #2;
        chk("mwr_bus_err",    32'(bus_err), 32'h0);

        // Last channel, highest byte of its window.
        tick();
        addr_result = 32'hFFFFFC9F;
        io_read     = 1'b1;
        exp_q.push_back(32'h00003333);
        tick(); #2;
        chk("ch3_cs", 32'(io_cs), 32'h8);
        tick(); #2;
        chk("ch3_rdata", rdata, 32'h00003333);
        tick();
        clear_req();

        // Out-of-window IO read just past the last channel.
        addr_result = 32'hFFFFFCA0;
        io_read     = 1'b1;
        exp_q.push_back(32'h0);
        #2;
        chk("oow_stall", 32'(stall), 32'h0);
        chk("oow_rdata", rdata,      32'h0);
        tick();
        clear_req();
        #2;
        chk("oow_cs",      32'(io_cs),   32'h0);
        chk("oow_bus_err", 32'(bus_err), 32'h1);

        // IO read below IO_BASE is also out of window.
        tick();
        addr_result = 32'h00000010;
        io_read     = 1'b1;
        exp_q.push_back(32'h0);
        #2;
        chk("low_stall", 32'(stall), 32'h0);
        tick();
        clear_req();
        #2;
        chk("low_cs", 32'(io_cs), 32'h0);

        // Reset asserted in the middle of an access.
        tick();
        io_ready    = 4'b0000;
        addr_result = 32'hFFFFFC70;
        io_read     = 1'b1;
        tick(); #2;
        chk("mid_cs_before", 32'(io_cs), 32'h2);
        reset = 1'b1;
        #1;
        chk("mid_rst_cs",      32'(io_cs),    32'h0);
        chk("mid_rst_rd_en",   32'(io_rd_en), 32'h0);
        chk("mid_rst_stall",   32'(stall),    32'h0);
        chk("mid_rst_bus_err", 32'(bus_err),  32'h0);
        clear_req();
        tick();
        reset    = 1'b0;
        io_ready = 4'b1111;

        // Memory has priority over a simultaneous IO request.
        tick();
        addr_result = 32'hFFFFFC70;
        mem_rdata   = 32'hCAFEF00D;
        mem_read    = 1'b1;
        io_read     = 1'b1;
        exp_q.push_back(32'hCAFEF00D);
        #2;
        chk("pri_rdata", rdata,      32'hCAFEF00D);
        chk("pri_stall", 32'(stall), 32'h0);
        tick();
        clear_req();
        #2;
        chk("pri_cs",      32'(io_cs),    32'h0);
        chk("pri_rd_en",   32'(io_rd_en), 32'h0);
        chk("pri_bus_err", 32'(bus_err),  32'h1);

        // Clear the sticky error, then a good read to load captured data.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("clr_bus_err", 32'(bus_err), 32'h0);
        tick();
        addr_result = 32'hFFFFFC70;
        io_read     = 1'b1;
        exp_q.push_back(32'h0000A5A5);
        tick(); tick(); tick();
        clear_req();

        // Timeout: ready never arrives on channel 2.
        io_ready    = 4'b0000;
        addr_result = 32'hFFFFFC80;
        io_read     = 1'b1;
        exp_q.push_back(32'h0);
        for (int i = 1; i <= 15; i++) begin
            tick(); #2;
            chk("to_acc_stall", 32'(stall), 32'h1);
        end
        chk("to_acc_cs", 32'(io_cs), 32'h4);
        tick(); #2;
        chk("to_done_stall",   32'(stall),    32'h0);
        chk("to_done_rdata",   rdata,         32'h0);
        chk("to_done_bus_err", 32'(bus_err),  32'h1);
        chk("to_done_cs",      32'(io_cs),    32'h0);
        tick();
        clear_req();

        // Later good access leaves the error flag set.
        io_ready    = 4'b1111;
        addr_result = 32'hFFFFFC90;
        io_read     = 1'b1;
        exp_q.push_back(32'h00003333);
        tick(); tick(); #2;
        chk("post_rdata",   rdata,         32'h00003333);
        chk("post_bus_err", 32'(bus_err),  32'h1);
        tick();
        clear_req();

        tick(); tick();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
